seq_chunk_adder: RTL

Parametrised multi-cycle adder/subtractor. It processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first, and holds the inter-chunk carry in a register. A start/done handshake replaces the fixed-width purely combinational ripple adders. Intended for datapaths that trade latency for a narrow carry chain; CHUNK = WIDTH degenerates to a single-cycle registered adder.

---
 rtl/seq_chunk_adder_if.sv | 27 ++
 rtl/seq_chunk_adder.sv | 112 +++++++++++
 2 files changed

// File: rtl/seq_chunk_adder_if.sv
// Operand/result bundle for the chunked adder: start/done handshake plus data.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  // Requester side: issues operations and observes results.
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );

  // Adder side: accepts operations and returns results.
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// carrying between chunks in a register. Subtraction is A + ~B + ~borrow_in.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic          clk,
  input logic          rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH < 2) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;      // already inverted for subtraction
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK:0]    chunk_sum;
  logic              last_chunk;

  // Narrow carry chain: only one CHUNK-wide slice is added per cycle.
  assign a_chunk    = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_chunk    = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

  // Next-state and datapath updates; every _d defaults to hold.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (last_chunk) begin
          // Signed overflow: like-signed operands producing a differently signed result.
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight operation and clears results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule
